cell16: RTL and testbench
=========================

CELL16 -- requirements
Module: cell16

Interface
REQ-001 The module SHALL have parameter RESET_VAL, default 1'b0, giving the value Q takes under asynchronous reset.
REQ-002 The module SHALL have port clk, input, 1 bit: the single system clock (50 MHz fast clock); all state is clocked on its rising edge.
REQ-003 The module SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port enp, input, 1 bit: one-clk-wide pulse marking the rising edge of the slow 1.79 MHz POKEY clock; state updates only when enp=1.
REQ-005 The module SHALL have port Shift, input, 1 bit: load/shift control; when sampled high, D is captured.
REQ-006 The module SHALL have port R, input, 1 bit: synchronous clear; when sampled high, Q is cleared.
REQ-007 The module SHALL have port D, input, 1 bit: serial data in.
REQ-008 The module SHALL have port Q, output, 1 bit: registered cell output.
REQ-009 Positional port order SHALL be enp, clk, Shift, R, D, Q, reset_n; reset_n SHALL be last so existing 6-port instantiations stay aligned; every instance SHALL drive reset_n.

Function
REQ-010 Q SHALL be driven directly from a single flip-flop, with no combinational path from any input to Q.
REQ-011 On a clk rising edge with enp=0, Q SHALL hold, regardless of Shift, R and D.
REQ-012 On a clk rising edge with enp=1 and R=1, Q SHALL become 0.
REQ-013 On a clk rising edge with enp=1, R=0 and Shift=1, Q SHALL become D.
REQ-014 On a clk rising edge with enp=1, R=0 and Shift=0, Q SHALL hold.
REQ-015 R SHALL take priority over Shift when both are 1 (result 0).
REQ-016 Latency SHALL be one enp event: a value loaded at an enp edge is visible on Q immediately after that edge and stays until the next qualifying enp edge.
REQ-017 Control inputs SHALL be assumed stable around each enp (driven from the slow-clock falling phase); no input synchronisation SHALL be performed inside the cell.
REQ-018 Shift or R held high across N enp pulses SHALL act N times; with Shift held and D constant, Q SHALL stay at D.
REQ-019 The cell SHALL chain directly: the Q of one instance feeding the D of the next, with a common Shift, SHALL form a shift register advancing one stage per qualifying enp.

Reset
REQ-020 When reset_n=0, Q SHALL take RESET_VAL immediately, without waiting for clk.
REQ-021 While reset_n=0, enp, Shift, R and D SHALL be ignored.
REQ-022 After reset_n deasserts, the first update SHALL occur at the first clk edge with enp=1; reset mid-operation SHALL discard any pending load.

Structure
REQ-023 Cell16 SHALL be flat with no sub-modules; RESET_VAL is its only parameter and no shared package SHALL be required.
REQ-024 A shared POKEY package, where present, SHALL hold the slow-clock edge-enable convention (enp rising, enn falling).
REQ-025 The enp and enn pulse generators SHALL live outside this cell, one instance per chip, and SHALL NOT be duplicated in each cell.

Verification
REQ-026 Reset: reset_n=0 with Q previously 1 -> Q=0 at once (RESET_VAL=0); release with Shift=R=0 -> Q stays 0.
REQ-027 Load: D=1, Shift=1 set after the slow-clock falling edge and held one slow period -> Q=1 exactly at the next enp clk edge, then holds after Shift=0.
REQ-028 Clear: Q=1, R=1 for one slow period -> Q=0 at the next enp; Shift=1 together with R=1 -> Q=0.
REQ-029 Hold: toggle D with Shift=0 and R=0 for 1000 ns -> Q unchanged; Shift=1 with enp forced low -> Q unchanged.
REQ-030 Chain: 4 instances in series, serial input pattern 1,0,1,1, Shift held high -> last Q equals first input after 4 enp pulses.
REQ-031 Async reset mid-operation: reset_n pulsed low between enp pulses while Shift=1 and D=1 -> Q=RESET_VAL immediately, reloads 1 at the first enp after release.

Source files
------------

// File: rtl/cell16_pkg.sv
// Shared POKEY slow-clock conventions: enp marks the slow-clock rising edge and
// enn the falling edge. Each is a one-clk_sys-wide pulse from a single per-chip generator.
package cell16_pkg;

  typedef enum logic [0:0] {
    EDGE_ENP = 1'b0,
    EDGE_ENN = 1'b1
  } slow_edge_e;

  // Ratio of the 50 MHz fast clock to the ~1.79 MHz POKEY clock, rounded.
  localparam int unsigned SLOW_DIV = 28;

  // Control signals are launched on the enn phase and sampled on the enp phase.
  function automatic slow_edge_e sample_edge();
    return EDGE_ENP;
  endfunction

  function automatic slow_edge_e launch_edge();
    return EDGE_ENN;
  endfunction

endpackage

// File: rtl/cell16.sv
// One-bit POKEY register cell: a single flop that updates only on enp.
// R clears the flop and takes priority over Shift, which loads D.
module cell16 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic enp,
  input  logic clk,
  input  logic Shift,
  input  logic R,
  input  logic D,
  output logic Q,
  input  logic reset_n
);

  logic r_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= RESET_VAL;
    end else if (enp) begin
      if (R) begin
        r_q <= 1'b0;
      end else if (Shift) begin
        r_q <= D;
      end
    end
  end

  assign Q = r_q;

endmodule

// File: tb/tb_cell16.sv
// Directed bench for cell16: reset, load, clear, hold, 4-stage chain and
// asynchronous reset in the middle of operation.
module tb_cell16;

  logic clk;
  logic reset_n;
  logic enp;
  logic shift;
  logic r;
  logic d;
  logic q;
  logic q_rv1;
  logic chain_shift;
  logic ser_d;
  logic [3:0] w_cq;

  int n_assert = 0;
  int n_fail   = 0;

  cell16 #(.RESET_VAL(1'b0)) u_dut (
    .enp(enp), .clk(clk), .Shift(shift), .R(r), .D(d), .Q(q), .reset_n(reset_n)
  );

  cell16 #(.RESET_VAL(1'b1)) u_dut_rv1 (
    .enp(enp), .clk(clk), .Shift(shift), .R(r), .D(d), .Q(q_rv1), .reset_n(reset_n)
  );

  for (genvar gi = 0; gi < 4; gi++) begin : g_chain
    cell16 #(.RESET_VAL(1'b0)) u_cell (
      .enp(enp), .clk(clk), .Shift(chain_shift), .R(1'b0),
      .D((gi == 0) ? ser_d : w_cq[(gi == 0) ? 0 : gi - 1]),
      .Q(w_cq[gi]), .reset_n(reset_n)
    );
  end

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", tag, obs, exp);
    end
  endtask

  // One enp pulse: raised on a falling edge, sampled by the next rising edge,
  // dropped on the following falling edge where outputs are then observed.
  task automatic pulse();
    @(negedge clk) enp = 1'b1;
    @(negedge clk) enp = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b1;
    enp = 1'b0; shift = 1'b0; r = 1'b0; d = 1'b0;
    chain_shift = 1'b0; ser_d = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("reset_q", {3'b0, q}, 4'b0000);
    check("reset_q_rv1", {3'b0, q_rv1}, 4'b0001);
    check("reset_chain", w_cq, 4'b0000);
    idle(2);
    // Inputs active during reset must be ignored.
    shift = 1'b1; d = 1'b1; enp = 1'b1;
    idle(2);
    check("reset_ignores_inputs", {3'b0, q}, 4'b0000);
    enp = 1'b0; shift = 1'b0; d = 1'b0;
    idle(1);
    reset_n = 1'b1;

    // Get Q to 1, then reset asynchronously away from any clock edge.
    shift = 1'b1; d = 1'b1;
    pulse();
    check("preload_q", {3'b0, q}, 4'b0001);
    shift = 1'b0; d = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    check("async_reset_immediate", {3'b0, q}, 4'b0000);
    idle(1);
    reset_n = 1'b1;
    pulse();
    check("release_stays_0", {3'b0, q}, 4'b0000);

    // Load.
    shift = 1'b1; d = 1'b1;
    idle(5);
    check("load_waits_enp", {3'b0, q}, 4'b0000);
    pulse();
    check("load_q", {3'b0, q}, 4'b0001);
    shift = 1'b0; d = 1'b0;
    pulse();
    check("load_holds", {3'b0, q}, 4'b0001);

    // Clear, alone and against Shift.
    r = 1'b1;
    pulse();
    check("clear_q", {3'b0, q}, 4'b0000);
    r = 1'b0; shift = 1'b1; d = 1'b1;
    pulse();
    check("reload_q", {3'b0, q}, 4'b0001);
    r = 1'b1;
    pulse();
    check("r_over_shift", {3'b0, q}, 4'b0000);
    r = 1'b0;
    pulse();
    check("shift_held_constant_d", {3'b0, q}, 4'b0001);
    pulse();
    check("shift_held_again", {3'b0, q}, 4'b0001);
    shift = 1'b0;

    // Hold: D toggles for 1000 ns with Shift=R=0 and enp still pulsing.
    for (int i = 0; i < 25; i++) begin
      d = ~d;
      pulse();
    end
    check("hold_d_toggle", {3'b0, q}, 4'b0001);
    // Everything active but enp held low.
    shift = 1'b1; d = 1'b0; r = 1'b1;
    idle(10);
    check("hold_enp_low", {3'b0, q}, 4'b0001);
    r = 1'b0;
    pulse();
    check("shift_loads_0", {3'b0, q}, 4'b0000);
    shift = 1'b0;

    // Chain: serial 1,0,1,1 advances one stage per enp.
    chain_shift = 1'b1;
    ser_d = 1'b1; pulse();
    check("chain_step1", w_cq, 4'b0001);
    ser_d = 1'b0; pulse();
    check("chain_step2", w_cq, 4'b0010);
    ser_d = 1'b1; pulse();
    check("chain_step3", w_cq, 4'b0101);
    ser_d = 1'b1; pulse();
    check("chain_step4", w_cq, 4'b1011);
    check("chain_last_is_first", {3'b0, w_cq[3]}, 4'b0001);
    chain_shift = 1'b0;

    // Async reset between enp pulses while Shift=1, D=1.
    shift = 1'b1; d = 1'b1;
    pulse();
    check("midop_loaded", {3'b0, q}, 4'b0001);
    idle(3);
    #5 reset_n = 1'b0;
    #1;
    check("midop_reset_q", {3'b0, q}, 4'b0000);
    check("midop_reset_q_rv1", {3'b0, q_rv1}, 4'b0001);
    check("midop_reset_chain", w_cq, 4'b0000);
    idle(1);
    reset_n = 1'b1;
    idle(4);
    check("midop_no_update_before_enp", {3'b0, q}, 4'b0000);
    pulse();
    check("midop_reload", {3'b0, q}, 4'b0001);
    shift = 1'b0; d = 1'b0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
